// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter for the shared UART
// transmit packet stream. One source owns the stream from SoP to EoP. Bytes
// pass through a one-entry output register with a valid/ready handshake.
// Build option: define UART_TX_ARB_TIMEOUT_EN to enable the stall watchdog,
// which revokes the grant from a source that stops presenting bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDW            = $clog2(NUM_REQ)
) (
  input  logic                   ipClk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     ipReq,
  input  logic [NUM_REQ-1:0]     ipValid,
  input  logic [NUM_REQ-1:0]     ipSoP,
  input  logic [NUM_REQ-1:0]     ipEoP,
  input  logic [8*NUM_REQ-1:0]   ipData,
  input  logic [8*NUM_REQ-1:0]   ipSource,
  input  logic [8*NUM_REQ-1:0]   ipDestination,
  input  logic [8*NUM_REQ-1:0]   ipLength,
  output logic [NUM_REQ-1:0]     opReady,
  output logic [NUM_REQ-1:0]     opGrant,
  output logic                   opTxValid,
  output logic                   opTxSoP,
  output logic                   opTxEoP,
  output logic [7:0]             opTxData,
  output logic [7:0]             opTxSource,
  output logic [7:0]             opTxDestination,
  output logic [7:0]             opTxLength,
  input  logic                   ipTxReady,
  output logic                   opTimeout,
  output logic [IDW-1:0]         opTimeoutId
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
  } txBeat_t;

  logic [0:0]     state;
  // lastGrant doubles as the index of the current owner while in GRANT
  logic [IDW-1:0] lastGrant;
  logic [IDW-1:0] pickIdx, hiIdx, loIdx;
  logic           hiFound;
  logic           selValid;
  txBeat_t        selBeat, txReg;
  logic           regFree, accept, acceptEop, timeoutHit;

  // Rotating priority: lowest requester above lastGrant, else lowest overall
  always_comb begin
    hiFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (ipReq[i]) begin
        loIdx = IDW'(i);
        if (i > int'(lastGrant)) begin
          hiFound = 1'b1;
          hiIdx   = IDW'(i);
        end
      end
    end
    pickIdx = hiFound ? hiIdx : loIdx;
  end

  // Mux the granted source's byte and header fields
  always_comb begin
    selValid = 1'b0;
    selBeat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lastGrant == IDW'(i)) begin
        selValid     = ipValid[i];
        selBeat.sop  = ipSoP[i];
        selBeat.eop  = ipEoP[i];
        selBeat.data = ipData[8*i +: 8];
        selBeat.src  = ipSource[8*i +: 8];
        selBeat.dst  = ipDestination[8*i +: 8];
        selBeat.len  = ipLength[8*i +: 8];
      end
    end
  end

  assign regFree   = !opTxValid || ipTxReady;
  assign accept    = (state == GRANT) && selValid && regFree;
  assign acceptEop = accept && selBeat.eop;

  // Accept strobe goes only to the owner, and only when a load happens
  always_comb begin
    opReady = '0;
    if (accept) opReady[lastGrant] = 1'b1;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] wdCnt;
  logic        stall;

  // Only a silent owner counts; downstream backpressure is not a stall
  assign stall      = (state == GRANT) && !selValid;
  assign timeoutHit = stall && (wdCnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counter and revocation report
  always_ff @(posedge ipClk) begin
    if (reset) begin
      wdCnt       <= '0;
      opTimeout   <= 1'b0;
      opTimeoutId <= '0;
    end else begin
      opTimeout <= timeoutHit;
      if (timeoutHit) opTimeoutId <= lastGrant;
      if (state == IDLE || accept) wdCnt <= '0;
      else if (stall)              wdCnt <= wdCnt + 16'd1;
    end
  end
`else
  assign timeoutHit  = 1'b0;
  assign opTimeout   = 1'b0;
  assign opTimeoutId = '0;
`endif

  // Grant FSM: arbitrate in IDLE, hold the owner until EoP or revocation
  always_ff @(posedge ipClk) begin
    if (reset) begin
      state     <= IDLE;
      opGrant   <= '0;
      lastGrant <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|ipReq) begin
            state     <= GRANT;
            opGrant   <= NUM_REQ'(1) << pickIdx;
            lastGrant <= pickIdx;
          end
        end
        default: begin
          if (acceptEop || timeoutHit) begin
            state   <= IDLE;
            opGrant <= '0;
          end
        end
      endcase
    end
  end

  // Output register: load on accept, otherwise drain when the transmitter takes it
  always_ff @(posedge ipClk) begin
    if (reset) begin
      opTxValid <= 1'b0;
      txReg     <= '0;
    end else if (accept) begin
      opTxValid <= 1'b1;
      txReg     <= selBeat;
    end else if (opTxValid && ipTxReady) begin
      opTxValid <= 1'b0;
    end
  end

  assign opTxSoP         = txReg.sop;
  assign opTxEoP         = txReg.eop;
  assign opTxData        = txReg.data;
  assign opTxSource      = txReg.src;
  assign opTxDestination = txReg.dst;
  assign opTxLength      = txReg.len;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for single-packet and backpressure
// flows, hand sequences for request drop / reset / watchdog, and randomized
// traffic checked against a packet-level scoreboard and rotation model.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int TO = 8;

  logic            ipClk = 1'b0;
  logic            reset;
  logic [NR-1:0]   ipReq, ipValid, ipSoP, ipEoP, opReady, opGrant;
  logic [8*NR-1:0] ipData, ipSource, ipDestination, ipLength;
  logic            opTxValid, opTxSoP, opTxEoP, ipTxReady, opTimeout;
  logic [7:0]      opTxData, opTxSource, opTxDestination, opTxLength;
  logic [0:0]      opTimeoutId;

  int nChecks = 0;
  int nFail   = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .ipClk(ipClk), .reset(reset), .ipReq(ipReq), .ipValid(ipValid),
    .ipSoP(ipSoP), .ipEoP(ipEoP), .ipData(ipData), .ipSource(ipSource),
    .ipDestination(ipDestination), .ipLength(ipLength), .opReady(opReady),
    .opGrant(opGrant), .opTxValid(opTxValid), .opTxSoP(opTxSoP),
    .opTxEoP(opTxEoP), .opTxData(opTxData), .opTxSource(opTxSource),
    .opTxDestination(opTxDestination), .opTxLength(opTxLength),
    .ipTxReady(ipTxReady), .opTimeout(opTimeout), .opTimeoutId(opTimeoutId)
  );

  always #5 ipClk = ~ipClk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic clearInputs();
    ipReq = '0; ipValid = '0; ipSoP = '0; ipEoP = '0;
    ipData = '0; ipDestination = '0; ipLength = '0;
    ipTxReady = 1'b1;
    for (int s = 0; s < NR; s++) ipSource[8*s +: 8] = 8'(s);
  endtask

  task automatic resetDut();
    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge ipClk);
    #1 reset = 1'b0;
  endtask

  // One byte from source s; waits (bounded) for the accept strobe, then
  // checks the byte sits in the output register after the edge.
  task automatic pushByte(input int s, input logic [7:0] d, input logic sop,
                          input logic eop, input logic req, input string nm);
    int n;
    n = 0;
    ipReq[s] = req; ipValid[s] = 1'b1; ipSoP[s] = sop; ipEoP[s] = eop;
    ipData[8*s +: 8] = d; ipDestination[8*s +: 8] = 8'h33; ipLength[8*s +: 8] = 8'd4;
    @(negedge ipClk);
    while (!opReady[s] && n < 20) begin
      @(negedge ipClk);
      n++;
    end
    check({nm, " ready"}, 32'(opReady[s]), 32'd1);
    @(posedge ipClk);
    #1 ipValid[s] = 1'b0;
    check({nm, " byte"}, {opTxValid, opTxSoP, opTxEoP, opTxSource, opTxData},
          {1'b1, sop, eop, 8'(s), d});
  endtask

  // ---------------- table of per-cycle vectors ----------------
  typedef struct {
    logic [1:0] req, vld;
    logic       sop, eop;
    logic [7:0] data;
    logic       txr;
    logic [1:0] eGnt, eRdy;
    logic       eTxv;
    logic [7:0] eData;
    logic       eSop, eEop;
    logic [7:0] eSrc;
  } vec_t;
  vec_t vecs[16];

  // ---------------- packet-level scoreboard ----------------
  typedef struct {
    logic [7:0] data, dst, len;
    logic       sop, eop;
  } beat_t;
  beat_t srcQ[NR][$];
  beat_t expQ[NR][$];
  int    grantOrder[$];

  task automatic addPacket(input int s, input int len, input int pid);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      b.dst  = 8'(pid);
      b.len  = 8'(len);
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      srcQ[s].push_back(b);
      expQ[s].push_back(b);
    end
  endtask

  // Reactive sources and sink; must be entered straight after resetDut so the
  // rotation model starts from "last winner = NR-1".
  task automatic runTraffic(input int vPct, input int rPct, input int maxCyc, input string nm);
    int            stallRun[NR];
    logic [NR-1:0] prevGnt, prevReq, expGnt, rdy;
    int            modelLast, openSrc, src, pick, left;
    logic          busy;
    beat_t         want;
    prevGnt = '0; prevReq = '0; modelLast = NR - 1; openSrc = -1;
    for (int s = 0; s < NR; s++) stallRun[s] = 0;
    for (int cyc = 0; cyc < maxCyc; cyc++) begin
      busy = 1'b0;
      for (int s = 0; s < NR; s++) if (expQ[s].size() > 0) busy = 1'b1;
      if (!busy) break;
      for (int s = 0; s < NR; s++) begin
        if (srcQ[s].size() > 0) begin
          ipReq[s]   = 1'b1;
          ipValid[s] = (stallRun[s] >= 3) || ($urandom_range(99) < vPct);
          ipSoP[s]   = srcQ[s][0].sop;
          ipEoP[s]   = srcQ[s][0].eop;
          ipData[8*s +: 8]        = srcQ[s][0].data;
          ipDestination[8*s +: 8] = srcQ[s][0].dst;
          ipLength[8*s +: 8]      = srcQ[s][0].len;
        end else begin
          ipReq[s] = 1'b0; ipValid[s] = 1'b0;
        end
        stallRun[s] = (ipReq[s] && !ipValid[s]) ? stallRun[s] + 1 : 0;
      end
      ipTxReady = ($urandom_range(99) < rPct);
      @(negedge ipClk);
      // After an ungranted cycle, the grant must go to the next requester in rotation
      if (prevGnt == '0) begin
        expGnt = '0;
        if (prevReq != '0) begin
          pick = -1;
          for (int k = 1; k <= NR; k++)
            if (pick < 0 && prevReq[(modelLast + k) % NR]) pick = (modelLast + k) % NR;
          expGnt[pick] = 1'b1;
          modelLast = pick;
          grantOrder.push_back(pick);
        end
        check({nm, " grant"}, 32'(opGrant), 32'(expGnt));
      end
      check({nm, " ready legal"},
            32'(((opReady & ~opGrant) == '0) && ((opReady & ~ipValid) == '0) && $onehot0(opReady)), 32'd1);
      check({nm, " no timeout"}, 32'(opTimeout), 32'd0);
      if (opTxValid && ipTxReady) begin
        src = int'(opTxSource);
        if (src >= NR || expQ[src].size() == 0) begin
          nChecks++; nFail++;
          $display("FAIL %s stray byte: got src %0d data %0h expected no byte", nm, src, opTxData);
        end else begin
          want = expQ[src].pop_front();
          check({nm, " byte"}, {opTxSoP, opTxEoP, opTxData, opTxDestination, opTxLength},
                {want.sop, want.eop, want.data, want.dst, want.len});
          if (opTxSoP) begin
            check({nm, " no interleave"}, 32'(openSrc), 32'hFFFF_FFFF);
            openSrc = src;
          end else begin
            check({nm, " same packet"}, 32'(openSrc), 32'(src));
          end
          if (opTxEoP) openSrc = -1;
        end
      end
      prevGnt = opGrant;
      prevReq = ipReq;
      rdy     = opReady;
      @(posedge ipClk);
      #1;
      for (int s = 0; s < NR; s++) if (rdy[s]) void'(srcQ[s].pop_front());
    end
    left = 0;
    for (int s = 0; s < NR; s++) begin
      left += expQ[s].size();
      srcQ[s].delete();
      expQ[s].delete();
    end
    check({nm, " all bytes delivered"}, 32'(left), 32'd0);
    clearInputs();
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    resetDut();

    // Reset state
    check("rst grant", 32'(opGrant), 32'd0);
    check("rst txvalid", 32'(opTxValid), 32'd0);
    check("rst txfields", {opTxSoP, opTxEoP, opTxData, opTxSource, opTxDestination, opTxLength}, 32'd0);
    check("rst ready", 32'(opReady), 32'd0);
    check("rst timeout", {opTimeout, opTimeoutId}, 32'd0);

    // Source 0 sends 11..44, then source 1 sends AA..DD under ready 1,0,0,1
    //           req    vld    sop   eop   data   txr  | eGnt   eRdy   eTxv  eData  eSop  eEop  eSrc
    vecs[0]  = '{2'b01, 2'b01, 1'b1, 1'b0, 8'h11, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{2'b01, 2'b01, 1'b1, 1'b0, 8'h11, 1'b1, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 8'h22, 1'b1, 2'b01, 2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{2'b01, 2'b01, 1'b0, 1'b0, 8'h33, 1'b1, 2'b01, 2'b01, 1'b1, 8'h22, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{2'b01, 2'b01, 1'b0, 1'b1, 8'h44, 1'b1, 2'b01, 2'b01, 1'b1, 8'h33, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 8'h44, 1'b0, 1'b1, 8'd0};
    vecs[6]  = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{2'b10, 2'b10, 1'b1, 1'b0, 8'hAA, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{2'b10, 2'b10, 1'b1, 1'b0, 8'hAA, 1'b1, 2'b10, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{2'b10, 2'b10, 1'b0, 1'b0, 8'hBB, 1'b0, 2'b10, 2'b00, 1'b1, 8'hAA, 1'b1, 1'b0, 8'd1};
    vecs[10] = '{2'b10, 2'b10, 1'b0, 1'b0, 8'hBB, 1'b0, 2'b10, 2'b00, 1'b1, 8'hAA, 1'b1, 1'b0, 8'd1};
    vecs[11] = '{2'b10, 2'b10, 1'b0, 1'b0, 8'hBB, 1'b1, 2'b10, 2'b10, 1'b1, 8'hAA, 1'b1, 1'b0, 8'd1};
    vecs[12] = '{2'b10, 2'b10, 1'b0, 1'b0, 8'hCC, 1'b1, 2'b10, 2'b10, 1'b1, 8'hBB, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{2'b10, 2'b10, 1'b0, 1'b1, 8'hDD, 1'b1, 2'b10, 2'b10, 1'b1, 8'hCC, 1'b0, 1'b0, 8'd1};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b1, 8'hDD, 1'b0, 1'b1, 8'd1};
    vecs[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    for (int i = 0; i < 16; i++) begin
      ipReq = vecs[i].req; ipValid = vecs[i].vld;
      ipSoP = {NR{vecs[i].sop}}; ipEoP = {NR{vecs[i].eop}};
      ipData = {NR{vecs[i].data}}; ipTxReady = vecs[i].txr;
      @(negedge ipClk);
      check($sformatf("vec%0d grant", i), 32'(opGrant), 32'(vecs[i].eGnt));
      check($sformatf("vec%0d ready", i), 32'(opReady), 32'(vecs[i].eRdy));
      check($sformatf("vec%0d txvalid", i), 32'(opTxValid), 32'(vecs[i].eTxv));
      if (vecs[i].eTxv)
        check($sformatf("vec%0d txbyte", i), {opTxSoP, opTxEoP, opTxSource, opTxData},
              {vecs[i].eSop, vecs[i].eEop, vecs[i].eSrc, vecs[i].eData});
      @(posedge ipClk);
      #1;
    end
    clearInputs();

    // Source 1 drops ipReq after byte 2; the grant must survive to EoP
    pushByte(1, 8'h61, 1'b1, 1'b0, 1'b1, "drop b1");
    pushByte(1, 8'h62, 1'b0, 1'b0, 1'b1, "drop b2");
    pushByte(1, 8'h63, 1'b0, 1'b0, 1'b0, "drop b3");
    check("drop grant held", 32'(opGrant), 32'b10);
    pushByte(1, 8'h64, 1'b0, 1'b1, 1'b0, "drop b4");
    check("drop grant released", 32'(opGrant), 32'd0);
    clearInputs();

    // Contention: three 2-byte packets each, requested together
    resetDut();
    grantOrder.delete();
    for (int p = 0; p < 3; p++) begin
      addPacket(0, 2, p);
      addPacket(1, 2, 10 + p);
    end
    runTraffic(100, 100, 200, "cont");
    check("cont grant count", 32'(grantOrder.size()), 32'd6);
    for (int i = 0; i < grantOrder.size(); i++)
      check($sformatf("cont order%0d", i), 32'(grantOrder[i]), 32'(i % 2));

    // Reset in the middle of a packet
    resetDut();
    pushByte(0, 8'h71, 1'b1, 1'b0, 1'b1, "rst b1");
    pushByte(0, 8'h72, 1'b0, 1'b0, 1'b1, "rst b2");
    reset = 1'b1;
    @(posedge ipClk);
    #1;
    check("midrst txvalid", 32'(opTxValid), 32'd0);
    check("midrst grant", 32'(opGrant), 32'd0);
    reset = 1'b0; ipReq = 2'b11; ipValid = 2'b00;
    @(posedge ipClk);
    #1;
    check("midrst first grant", 32'(opGrant), 32'b01);

    // Owner goes silent after SoP while source 1 waits
    resetDut();
    ipReq[1] = 1'b1;
    pushByte(0, 8'h81, 1'b1, 1'b0, 1'b1, "to sop");
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      @(posedge ipClk);
      #1;
      if (k < TO) begin
        check($sformatf("to quiet%0d", k), 32'(opTimeout), 32'd0);
        check($sformatf("to held%0d", k), 32'(opGrant), 32'b01);
      end else begin
        check("to pulse", 32'(opTimeout), 32'd1);
        check("to id", 32'(opTimeoutId), 32'd0);
        check("to revoked", 32'(opGrant), 32'd0);
      end
    end
    @(posedge ipClk);
    #1;
    check("to pulse width", 32'(opTimeout), 32'd0);
    check("to next grant", 32'(opGrant), 32'b10);
`else
    for (int k = 1; k <= 2 * TO; k++) begin
      @(posedge ipClk);
      #1;
      check($sformatf("stall quiet%0d", k), {opTimeout, opTimeoutId}, 32'd0);
      check($sformatf("stall held%0d", k), 32'(opGrant), 32'b01);
    end
`endif

    // Randomized traffic against the scoreboard and rotation model
    resetDut();
    grantOrder.delete();
    for (int p = 0; p < 30; p++) addPacket($urandom_range(NR - 1), $urandom_range(1, 5), p);
    runTraffic(75, 60, 3000, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end
endmodule
